stream_mux_rr: RTL and testbench

Parametrised N-channel streaming multiplexer and the successor of the fixed 4:1 byte select mux. It arbitrates among NUM_CH valid/ready input streams with round-robin fairness and holds the grant for a whole packet. It forwards one beat per cycle through a registered output stage and sits between datapath producers and any single shared consumer.

---
 rtl/stream_mux_pkg.sv | 19 +
 rtl/stream_mux_rr_if.sv | 32 +++
 rtl/stream_mux_rr_arbiter.sv | 31 +++
 rtl/stream_mux_rr.sv | 131 +++++++++++++
 tb/tb_stream_mux_rr.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// Holds the FSM state encoding, channel-index width and the wrap-around step.
package stream_mux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // A single channel still needs a one-bit index so ports never collapse to zero width.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int num_ch);
    return (idx + 1 >= num_ch) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Bundle of the N input streams, the single output stream and the grant status.
// The slave modport is the multiplexer's view; master is the producer/consumer side.
interface stream_mux_rr_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  import stream_mux_pkg::*;

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_ready;
  logic [CH_W-1:0]          grant_ch;
  logic                     grant_vld;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, grant_ch, grant_vld
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, grant_ch, grant_vld
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Stateless round-robin pick: first requester after ptr_i, wrapping modulo NUM_CH.
// The pointer itself is owned by the caller.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   gnt_o,
  output logic              gnt_vld_o
);

  logic [CH_W-1:0] idx;

  // Walk ptr+1 .. ptr+NUM_CH; the last step lands back on ptr itself.
  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    idx       = ptr_i;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'(rr_next(int'(idx), NUM_CH));
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_o     = idx;
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with round-robin arbitration and a registered output.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant for a whole packet and forward in_last.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            rst,
  stream_mux_rr_if.slave mux_if
);

  localparam int CH_W = ch_width(NUM_CH);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   lock_q, lock_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic [CH_W-1:0]   arb_gnt;
  logic              arb_vld;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_vld;
  logic              slot_free;
  logic              rdy_en;
  logic              accept;
  logic [NUM_CH-1:0] in_ready_w;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i     (mux_if.in_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_vld_o (arb_vld)
  );

  // A locked owner keeps the grant even while its in_valid is low, so others starve.
  always_comb begin
    grant_ch  = arb_gnt;
    grant_vld = arb_vld;
    if (state_q == ST_LOCKED) begin
      grant_ch  = lock_q;
      grant_vld = 1'b1;
    end
  end

  assign slot_free = !valid_q || mux_if.out_ready;
  assign rdy_en    = grant_vld && slot_free;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_data[gi]    = mux_if.in_data[gi*DATA_W +: DATA_W];
    assign in_ready_w[gi] = rdy_en && (grant_ch == CH_W'(gi));
  end

  assign accept = |(mux_if.in_valid & in_ready_w);

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic sel_last;
  assign sel_last = mux_if.in_last[grant_ch];
`else
  logic unused_last;
  assign unused_last = ^mux_if.in_last;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept) begin
      data_d  = ch_data[grant_ch];
      valid_d = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
      last_d = sel_last;
      if (state_q == ST_IDLE) begin
        ptr_d = grant_ch;
        if (!sel_last) begin
          state_d = ST_LOCKED;
          lock_d  = grant_ch;
        end
      end else if (sel_last) begin
        state_d = ST_IDLE;
      end
`else
      last_d = 1'b0;
      ptr_d  = grant_ch;
`endif
    end else if (valid_q && mux_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= CH_W'(NUM_CH - 1);
      lock_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Handshake outputs are forced quiet while reset is held, not just after the edge.
  assign mux_if.in_ready  = in_ready_w & {NUM_CH{!rst}};
  assign mux_if.grant_vld = grant_vld && !rst;
  assign mux_if.grant_ch  = grant_ch;
  assign mux_if.out_data  = data_q;
  assign mux_if.out_valid = valid_q;
  assign mux_if.out_last  = last_q;

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(in_ready_w));
  a_hold_on_stall : assert property (@(posedge clk) disable iff (rst)
    (valid_q && !mux_if.out_ready) |=> (valid_q && $stable(data_q) && $stable(last_q)));
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table-driven bench for stream_mux_rr (NUM_CH=4, DATA_W=8), both lock builds.
// Each row is driven at the falling edge and compared 1 time unit later.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
`ifdef STREAM_MUX_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  stream_mux_rr_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  stream_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .mux_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  last;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic        e_gvld;
    logic [1:0]  e_gch;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;   // out_last expected when packet lock is built in
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic [3:0] v, input logic [3:0] last, input logic [31:0] d,
                     input logic r, input logic [3:0] er, input logic eg, input logic [1:0] ec,
                     input logic eov, input logic [7:0] eod, input logic eol);
    vec_t t;
    t.v = v; t.last = last; t.data = d; t.rdy = r;
    t.e_rdy = er; t.e_gvld = eg; t.e_gch = ec; t.e_ov = eov; t.e_od = eod; t.e_ol = eol;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] last, input logic [31:0] d,
                       input logic r);
    bus.in_valid  = v;
    bus.in_last   = last;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  localparam logic [31:0] D = 32'h13121110;

  initial begin
    rst = 1'b1;
    drive(4'hF, 4'hF, D, 1'b1);

    // Round-robin over single-beat packets, drain, backpressure, simultaneous drain+accept
    add(4'hF, 4'hF, D, 1, 4'h1, 1, 0, 0, 8'h00, 0);
    add(4'hF, 4'hF, D, 1, 4'h2, 1, 1, 1, 8'h10, 1);
    add(4'hF, 4'hF, D, 1, 4'h4, 1, 2, 1, 8'h11, 1);
    add(4'hF, 4'hF, D, 1, 4'h8, 1, 3, 1, 8'h12, 1);
    add(4'hF, 4'hF, D, 1, 4'h1, 1, 0, 1, 8'h13, 1);
    add(4'h0, 4'hF, D, 1, 4'h0, 0, 0, 1, 8'h10, 1);
    add(4'h0, 4'hF, D, 1, 4'h0, 0, 0, 0, 8'h00, 0);
    add(4'h4, 4'hF, D, 0, 4'h4, 1, 2, 0, 8'h00, 0);
    for (int k = 0; k < 5; k++)
      add(4'h6, 4'hF, D, 0, 4'h0, 1, 1, 1, 8'h12, 1);
    add(4'h6, 4'hF, D, 1, 4'h2, 1, 1, 1, 8'h12, 1);
    add(4'h6, 4'hF, D, 1, 4'h4, 1, 2, 1, 8'h11, 1);
    add(4'h2, 4'hF, D, 1, 4'h2, 1, 1, 1, 8'h12, 1);
    add(4'h0, 4'hF, D, 1, 4'h0, 0, 0, 1, 8'h11, 1);
    add(4'h0, 4'hF, D, 1, 4'h0, 0, 0, 0, 8'h00, 0);
`ifdef STREAM_MUX_PKT_LOCK_EN
    // Channel 2 three-beat packet while channel 0 waits
    add(4'h5, 4'h1, 32'h13A01110, 1, 4'h4, 1, 2, 0, 8'h00, 0);
    add(4'h5, 4'h1, 32'h13A11110, 1, 4'h4, 1, 2, 1, 8'hA0, 0);
    add(4'h5, 4'h5, 32'h13A21110, 1, 4'h4, 1, 2, 1, 8'hA1, 0);
    add(4'h1, 4'h1, D,            1, 4'h1, 1, 0, 1, 8'hA2, 1);
    add(4'h0, 4'h0, D,            1, 4'h0, 0, 0, 1, 8'h10, 1);
    add(4'h0, 4'h0, D,            1, 4'h0, 0, 0, 0, 8'h00, 0);
    // Channel 1 owner stalls four cycles while channel 3 waits
    add(4'hA, 4'h8, 32'h3300B000, 1, 4'h2, 1, 1, 0, 8'h00, 0);
    add(4'h8, 4'h8, 32'h3300B000, 1, 4'h2, 1, 1, 1, 8'hB0, 0);
    for (int k = 0; k < 3; k++)
      add(4'h8, 4'h8, 32'h3300B000, 1, 4'h2, 1, 1, 0, 8'h00, 0);
    add(4'hA, 4'hA, 32'h3300B100, 1, 4'h2, 1, 1, 0, 8'h00, 0);
    add(4'h8, 4'h8, 32'h3300B100, 1, 4'h8, 1, 3, 1, 8'hB1, 1);
    add(4'h0, 4'h0, 32'h3300B100, 1, 4'h0, 0, 0, 1, 8'h33, 1);
    add(4'h0, 4'h0, 32'h3300B100, 1, 4'h0, 0, 0, 0, 8'h00, 0);
`else
    // Per-beat alternation between channels 0 and 1 with in_last low
    add(4'h3, 4'h0, D, 1, 4'h1, 1, 0, 0, 8'h00, 0);
    add(4'h3, 4'h0, D, 1, 4'h2, 1, 1, 1, 8'h10, 0);
    add(4'h3, 4'h0, D, 1, 4'h1, 1, 0, 1, 8'h11, 0);
    add(4'h3, 4'h0, D, 1, 4'h2, 1, 1, 1, 8'h10, 0);
    add(4'h0, 4'h0, D, 1, 4'h0, 0, 0, 1, 8'h11, 0);
    add(4'h0, 4'h0, D, 1, 4'h0, 0, 0, 0, 8'h00, 0);
    add(4'h8, 4'h8, D, 1, 4'h8, 1, 3, 0, 8'h00, 0);
    add(4'h0, 4'h0, D, 1, 4'h0, 0, 0, 1, 8'h13, 0);
    add(4'h0, 4'h0, D, 1, 4'h0, 0, 0, 0, 8'h00, 0);
`endif

    // Reset state with every channel requesting
    @(negedge clk);
    #1;
    check("rst in_ready",  32'(bus.in_ready),  32'h0);
    check("rst grant_vld", 32'(bus.grant_vld), 32'h0);
    check("rst out_valid", 32'(bus.out_valid), 32'h0);
    check("rst out_data",  32'(bus.out_data),  32'h0);
    check("rst out_last",  32'(bus.out_last),  32'h0);
    $display("reset: in_ready=%b grant_vld=%b out_valid=%b", bus.in_ready, bus.grant_vld, bus.out_valid);

    @(negedge clk);
    rst = 1'b0;
    foreach (vq[i]) begin
      if (i != 0) @(negedge clk);
      drive(vq[i].v, vq[i].last, vq[i].data, vq[i].rdy);
      #1;
      check($sformatf("r%0d in_ready", i),  32'(bus.in_ready),  32'(vq[i].e_rdy));
      check($sformatf("r%0d grant_vld", i), 32'(bus.grant_vld), 32'(vq[i].e_gvld));
      if (vq[i].e_gvld)
        check($sformatf("r%0d grant_ch", i), 32'(bus.grant_ch), 32'(vq[i].e_gch));
      check($sformatf("r%0d out_valid", i), 32'(bus.out_valid), 32'(vq[i].e_ov));
      if (vq[i].e_ov) begin
        check($sformatf("r%0d out_data", i), 32'(bus.out_data), 32'(vq[i].e_od));
        check($sformatf("r%0d out_last", i), 32'(bus.out_last), 32'(LOCK_EN & vq[i].e_ol));
      end
      $display("row %0d: in_valid=%b out_ready=%b in_ready=%b grant=%0d/%b out=%b:%h:%b",
               i, vq[i].v, vq[i].rdy, bus.in_ready, bus.grant_ch, bus.grant_vld,
               bus.out_valid, bus.out_data, bus.out_last);
    end

    // Reset asserted between edges in the middle of a channel-2 packet
    @(negedge clk);
    drive(4'h4, 4'h0, 32'h00C00000, 1'b1);
    #1;
    check("ar first in_ready", 32'(bus.in_ready), 32'h4);
    check("ar first grant_ch", 32'(bus.grant_ch), 32'h2);
    @(negedge clk);
    #1;
    check("ar beat out_valid", 32'(bus.out_valid), 32'h1);
    check("ar beat out_data",  32'(bus.out_data),  32'hC0);
    #1;
    rst = 1'b1;
    #1;
    check("ar out_valid", 32'(bus.out_valid), 32'h0);
    check("ar out_data",  32'(bus.out_data),  32'h0);
    check("ar in_ready",  32'(bus.in_ready),  32'h0);
    check("ar grant_vld", 32'(bus.grant_vld), 32'h0);
    $display("async reset: out_valid=%b in_ready=%b grant_vld=%b", bus.out_valid, bus.in_ready, bus.grant_vld);
    @(negedge clk);
    rst = 1'b0;
    drive(4'h5, 4'h1, 32'h00C01110, 1'b1);
    #1;
    check("ar rel grant_vld", 32'(bus.grant_vld), 32'h1);
    check("ar rel grant_ch",  32'(bus.grant_ch),  32'h0);
    check("ar rel in_ready",  32'(bus.in_ready),  32'h1);
    @(negedge clk);
    drive(4'h0, 4'h0, 32'h0, 1'b1);
    #1;
    check("ar rel out_valid", 32'(bus.out_valid), 32'h1);
    check("ar rel out_data",  32'(bus.out_data),  32'h10);
    check("ar rel out_last",  32'(bus.out_last),  32'(LOCK_EN));
    $display("after reset: out=%b:%h:%b", bus.out_valid, bus.out_data, bus.out_last);
    @(negedge clk);
    #1;
    check("ar drain out_valid", 32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
